// File: rtl/huffman_pkg.sv
// Symbol constants and prefix-code table shared by the Huffman encoder and decoder.
// Codes are stored left-aligned so the serializer always transmits bit [MAX_CODE_LEN-1].
package huffman_pkg;

   localparam int MAX_CODE_LEN = 4;

   localparam logic [2:0] SYM_NULL = 3'b000;
   localparam logic [2:0] SYM_A    = 3'b001;
   localparam logic [2:0] SYM_B    = 3'b010;
   localparam logic [2:0] SYM_C    = 3'b011;
   localparam logic [2:0] SYM_D    = 3'b100;
   localparam logic [2:0] SYM_E    = 3'b101;
   localparam logic [2:0] SYM_F    = 3'b110;
   localparam logic [2:0] SYM_INV  = 3'b111;

   typedef struct packed {
      logic [MAX_CODE_LEN-1:0] bits;
      logic [2:0]              len;
   } code_t;

   // A length of zero marks a symbol that has no codeword (NULL and 111).
   function automatic code_t code_of(input logic [2:0] sym);
      code_t c;
      c = '0;
      case (sym)
         SYM_A:   c = '{bits: 4'b0000, len: 3'd1};
         SYM_B:   c = '{bits: 4'b1010, len: 3'd3};
         SYM_C:   c = '{bits: 4'b1000, len: 3'd3};
         SYM_D:   c = '{bits: 4'b1110, len: 3'd3};
         SYM_E:   c = '{bits: 4'b1101, len: 3'd4};
         SYM_F:   c = '{bits: 4'b1100, len: 3'd4};
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/huffman_sym_fifo.sv
// Symbol FIFO for the Huffman encoder: DEPTH entries of 3 bits, pointers wrap modulo DEPTH.
// Push on a full FIFO and pop on an empty FIFO are ignored.
module huffman_sym_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [2:0]               din,
   output logic [2:0]               dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE   = 1;
   localparam logic [AW:0]   CNT_ONE   = 1;
   localparam logic [AW:0]   FULL_CNT  = DEPTH;

   logic [2:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          push_ok;
   logic          pop_ok;

   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign dout    = mem[rd_ptr];

   // NOTE: the storage array has no reset; count and pointers alone decide which entries are live.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= din;
   end

   // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
         if (push_ok && !pop_ok)      count <= count + CNT_ONE;
         else if (pop_ok && !push_ok) count <= count - CNT_ONE;
      end
   end

endmodule

// File: rtl/huffman_encoder.sv
// Huffman encoder: buffers 3-bit symbols and serializes their prefix codes MSB-first, one bit per clk.
// Optional saturating sym_count/bit_count statistics when HUFF_ENC_STATS_EN is defined.
module huffman_encoder
   import huffman_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       sym_in,
   input  logic             sym_valid,
   output logic             sym_ready,
   output logic             bit_out,
   output logic             bit_valid,
   output logic             busy,
   output logic             err
`ifdef HUFF_ENC_STATS_EN
   ,
   output logic [CNT_W-1:0] sym_count,
   output logic [CNT_W-1:0] bit_count
`endif
);

   if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("huffman_encoder: DEPTH must be a power of two >= 2");
   end
   if (CNT_W < 1) begin : g_bad_cnt_w
      $error("huffman_encoder: CNT_W must be >= 1");
   end

   typedef enum logic {IDLE, SHIFT} state_e;

   state_e                  state, state_n;
   logic [MAX_CODE_LEN-1:0] sh, sh_n;
   logic [2:0]              rem, rem_n;
   logic                    err_n;
   logic                    pop;
   logic                    load;
   code_t                   head;

   logic [2:0]              fifo_dout;
   logic                    fifo_full;
   logic                    fifo_empty;
   logic [$clog2(DEPTH):0]  fifo_count;

   assign sym_ready = !fifo_full;

   huffman_sym_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (sym_valid && sym_ready),
      .pop   (pop),
      .din   (sym_in),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign head = code_of(fifo_dout);

   // NOTE: every signal driven here gets a default first, so no path can leave one unassigned and infer a latch.
   always_comb begin
      state_n = state;
      sh_n    = sh;
      rem_n   = rem;
      err_n   = 1'b0;
      pop     = 1'b0;
      load    = 1'b0;
      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               pop   = 1'b1;
               load  = (head.len != 3'd0);
               err_n = (head.len == 3'd0);
            end
         end
         SHIFT: begin
            if (rem != 3'd0) begin
               sh_n  = {sh[MAX_CODE_LEN-2:0], 1'b0};
               rem_n = rem - 3'd1;
            end else begin
               // Last bit of the codeword: chain straight into the next entry if there is one.
               state_n = IDLE;
               sh_n    = '0;
               rem_n   = '0;
               if (!fifo_empty) begin
                  pop   = 1'b1;
                  load  = (head.len != 3'd0);
                  err_n = (head.len == 3'd0);
               end
            end
         end
         default: state_n = IDLE;
      endcase
      if (load) begin
         state_n = SHIFT;
         sh_n    = head.bits;
         rem_n   = head.len - 3'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         sh    <= '0;
         rem   <= '0;
         err   <= 1'b0;
      end else begin
         state <= state_n;
         sh    <= sh_n;
         rem   <= rem_n;
         err   <= err_n;
      end
   end

   // The shift register is cleared whenever the serializer idles, so bit_out is 0 in gaps.
   assign bit_out   = sh[MAX_CODE_LEN-1];
   assign bit_valid = (state == SHIFT);
   assign busy      = (fifo_count != '0) || (state == SHIFT);

`ifdef HUFF_ENC_STATS_EN
   localparam logic [CNT_W-1:0] STAT_ONE = 1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sym_count <= '0;
         bit_count <= '0;
      end else begin
         if (load && (sym_count != '1))      sym_count <= sym_count + STAT_ONE;
         if (bit_valid && (bit_count != '1)) bit_count <= bit_count + STAT_ONE;
      end
   end
`endif

endmodule

// File: tb/tb_huffman_encoder.sv
// Self-checking bench for huffman_encoder: a slot-schedule model of the output stream checked every
// cycle, plus literal expectations for each directed scenario. Define HUFF_ENC_STATS_EN to cover the counters.
module tb_huffman_encoder;

   localparam int DEPTH   = 4;
   localparam int CNT_W   = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [2:0] sym_in = 3'b000;
   logic       sym_valid = 1'b0;
   logic       sym_ready, bit_out, bit_valid, busy, err;
`ifdef HUFF_ENC_STATS_EN
   logic [CNT_W-1:0] sym_count, bit_count;
`endif

   huffman_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .sym_in    (sym_in),
      .sym_valid (sym_valid),
      .sym_ready (sym_ready),
      .bit_out   (bit_out),
      .bit_valid (bit_valid),
      .busy      (busy),
      .err       (err)
`ifdef HUFF_ENC_STATS_EN
      ,
      .sym_count (sym_count),
      .bit_count (bit_count)
`endif
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   // Model: every accepted symbol becomes a run of output slots (code bits, or one err slot for 000/111).
   // A token accepted at edge N starts at cycle max(N+1, end of previous token) and occupies the FIFO until then.
   int slot_kind [int];   // 0/1 = code bit value, 2 = err slot
   bit slot_first [int];
   int occ [int];         // FIFO occupancy during a cycle
   int next_free = 0;

   function automatic int occ_at(input int c);
      return occ.exists(c) ? occ[c] : 0;
   endfunction

   task automatic schedule(input int n, input logic [2:0] s);
      int val, len, start;
      case (s)
         3'b001:  begin val = 0;  len = 1; end
         3'b010:  begin val = 5;  len = 3; end
         3'b011:  begin val = 4;  len = 3; end
         3'b100:  begin val = 7;  len = 3; end
         3'b101:  begin val = 13; len = 4; end
         3'b110:  begin val = 12; len = 4; end
         default: begin val = 0;  len = 0; end
      endcase
      start = (next_free > n + 1) ? next_free : n + 1;
      for (int c = n; c < start; c++) occ[c] = occ_at(c) + 1;
      if (len == 0) begin
         slot_kind[start]  = 2;
         slot_first[start] = 1'b0;
         next_free = start + 1;
      end else begin
         for (int i = 0; i < len; i++) begin
            slot_kind[start + i]  = (val >> (len - 1 - i)) & 1;
            slot_first[start + i] = (i == 0);
         end
         next_free = start + len;
      end
   endtask

   always @(posedge clk) begin
      cyc = cyc + 1;
      if (reset) begin
         slot_kind.delete();
         slot_first.delete();
         occ.delete();
         next_free = 0;
      end else if (sym_valid && (occ_at(cyc - 1) < DEPTH)) begin
         schedule(cyc, sym_in);
      end
   end

   // Capture of the observed stream for the literal per-scenario checks.
   logic cap [$];
   int   n_err_seen = 0;
   bit   saw_not_ready = 1'b0;
   int   first_bv = -1;
   int   last_bv = -1;
   int   kind;
   bit   exp_bv, exp_bo, exp_err, exp_busy, exp_ready;
`ifdef HUFF_ENC_STATS_EN
   int   m_sym = 0;
   int   m_bits = 0;
`endif

   always @(negedge clk) begin
      if (reset) begin
         check("rst_bit_valid", bit_valid, 0);
         check("rst_bit_out", bit_out, 0);
         check("rst_err", err, 0);
         check("rst_busy", busy, 0);
         check("rst_sym_ready", sym_ready, 1);
`ifdef HUFF_ENC_STATS_EN
         m_sym  = 0;
         m_bits = 0;
         check("rst_sym_count", sym_count, 0);
         check("rst_bit_count", bit_count, 0);
`endif
      end else begin
         kind      = slot_kind.exists(cyc) ? slot_kind[cyc] : -1;
         exp_bv    = (kind == 0) || (kind == 1);
         exp_bo    = (kind == 1);
         exp_err   = (kind == 2);
         exp_busy  = exp_bv || (occ_at(cyc) > 0);
         exp_ready = (occ_at(cyc) < DEPTH);
         check("bit_valid", bit_valid, exp_bv);
         check("bit_out", bit_out, exp_bo);
         check("err", err, exp_err);
         check("busy", busy, exp_busy);
         check("sym_ready", sym_ready, exp_ready);
`ifdef HUFF_ENC_STATS_EN
         if (slot_first.exists(cyc) && slot_first[cyc] && (m_sym < CNT_MAX)) m_sym++;
         check("sym_count", sym_count, m_sym);
         check("bit_count", bit_count, m_bits);
         if (exp_bv && (m_bits < CNT_MAX)) m_bits++;
`endif
         if (bit_valid) begin
            cap.push_back(bit_out);
            if (first_bv < 0) first_bv = cyc;
            last_bv = cyc;
         end
         if (err) n_err_seen++;
         if (!sym_ready) saw_not_ready = 1'b1;
      end
   end

   // Stimulus helpers; all of them start and end just after a falling edge.
   task automatic send(input logic [2:0] s);
      bit ok;
      sym_in    = s;
      sym_valid = 1'b1;
      ok        = 1'b0;
      for (int t = 0; t < 100; t++) begin
         ok = sym_ready;
         @(negedge clk);
         if (ok) break;
      end
      check("send_accepted", ok, 1);
   endtask

   task automatic idle_in();
      sym_valid = 1'b0;
      sym_in    = 3'b000;
   endtask

   task automatic drain();
      bit done;
      done = 1'b0;
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         if (!busy && !bit_valid && !err) begin
            done = 1'b1;
            break;
         end
      end
      check("drain", done, 1);
   endtask

   task automatic clear_capture();
      cap.delete();
      n_err_seen    = 0;
      saw_not_ready = 1'b0;
      first_bv      = -1;
      last_bv       = -1;
   endtask

   task automatic expect_stream(input string name, input int n, input logic [31:0] bits);
      logic [31:0] got;
      got = '0;
      foreach (cap[i]) got = {got[30:0], cap[i]};
      check({name, "_len"}, cap.size(), n);
      check(name, got, bits);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check("post_rst_ready", sym_ready, 1);
      check("post_rst_busy", busy, 0);

      // Single A: one valid cycle carrying 0.
      clear_capture();
      send(3'b001);
      idle_in();
      drain();
      expect_stream("a_alone", 1, 32'b0);
      check("a_alone_err", n_err_seen, 0);

      // B C D E F back-to-back: contiguous 17-bit stream.
      clear_capture();
      send(3'b010); send(3'b011); send(3'b100); send(3'b101); send(3'b110);
      idle_in();
      drain();
      expect_stream("bcdef", 17, 32'b10110011111011100);
      check("bcdef_span", last_bv - first_bv + 1, 17);

      // Seven symbols while E is shifting: FIFO fills and ready drops.
      clear_capture();
      send(3'b101); send(3'b001); send(3'b010); send(3'b011);
      send(3'b100); send(3'b110); send(3'b001);
      idle_in();
      drain();
      expect_stream("fill", 19, 32'b1101010110011111000);
      check("fill_ready_dropped", saw_not_ready, 1);

      // B, invalid 111, A: one err cycle between the codewords.
      clear_capture();
      send(3'b010); send(3'b111); send(3'b001);
      idle_in();
      drain();
      expect_stream("b_inv_a", 4, 32'b1010);
      check("b_inv_a_err_pulses", n_err_seen, 1);
      check("b_inv_a_span", last_bv - first_bv + 1, 5);

      // Reset during the second bit of F aborts the codeword immediately.
      clear_capture();
      send(3'b110);
      idle_in();
      @(negedge clk);
      @(posedge clk);
      #1;
      check("f_bit2_valid", bit_valid, 1);
      check("f_bit2_value", bit_out, 1);
      reset = 1'b1;
      #1;
      check("abort_bit_valid", bit_valid, 0);
      check("abort_bit_out", bit_out, 0);
      check("abort_sym_ready", sym_ready, 1);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      clear_capture();
      send(3'b011);
      idle_in();
      drain();
      expect_stream("after_abort", 3, 32'b100);

      // Twenty A symbols streamed; counters saturate when present.
      clear_capture();
      for (int i = 0; i < 20; i++) send(3'b001);
      idle_in();
      drain();
      expect_stream("twenty_a", 20, 32'b0);
      check("twenty_a_span", last_bv - first_bv + 1, 20);
`ifdef HUFF_ENC_STATS_EN
      check("sym_count_sat", sym_count, 15);
      check("bit_count_sat", bit_count, 15);
`endif

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

endmodule
